// File: rtl/dcache_channel_arbiter.sv
// Shares NUM_CHANNELS memory-controller channels among NUM_CONSUMERS dcache requesters.
// Each channel runs IDLE -> REQ -> RESP; free channels are handed out round-robin.
module dcache_channel_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]              controller_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]    controller_read_address,
    input  logic [NUM_CHANNELS-1:0]              controller_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]    controller_read_data,
    output logic [NUM_CHANNELS-1:0]              controller_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]    controller_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]    controller_write_data,
    input  logic [NUM_CHANNELS-1:0]              controller_write_ready
);
    // Handshake: a request is raised on *_valid and held until the matching *_ready is
    // seen high at a clock edge; the requester then drops valid and the responder drops ready.
    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} chan_state_t;

    chan_state_t              state       [NUM_CHANNELS];
    logic [PTR_W-1:0]         owner       [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  op_write;
    logic [PTR_W-1:0]         rr_ptr;

    logic [NUM_CONSUMERS-1:0] owned;
    logic [NUM_CONSUMERS-1:0] pending;
    logic [NUM_CONSUMERS-1:0] taken;
    logic [NUM_CHANNELS-1:0]  grant;
    logic [PTR_W-1:0]         grant_owner [NUM_CHANNELS];
    logic [PTR_W-1:0]         next_ptr;
    int                       idx;

    always_comb begin
        owned = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state[c] != IDLE) owned[owner[c]] = 1'b1;
        end
        pending = (consumer_read_valid | consumer_write_valid) & ~owned;
    end

    // Channels in ascending order each take the next untaken pending consumer,
    // scanning from the pointer; the last grant made therefore sets the new pointer.
    always_comb begin
        taken    = '0;
        grant    = '0;
        next_ptr = rr_ptr;
        idx      = 0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            grant_owner[c] = '0;
            if (state[c] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    idx = int'(rr_ptr) + k;
                    if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
                    if (!grant[c] && pending[idx] && !taken[idx]) begin
                        grant[c]       = 1'b1;
                        taken[idx]     = 1'b1;
                        grant_owner[c] = PTR_W'(idx);
                        next_ptr       = (idx + 1 == NUM_CONSUMERS) ? '0 : PTR_W'(idx + 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr                   <= '0;
            op_write                 <= '0;
            consumer_read_ready      <= '0;
            consumer_read_data       <= '0;
            consumer_write_ready     <= '0;
            controller_read_valid    <= '0;
            controller_read_address  <= '0;
            controller_write_valid   <= '0;
            controller_write_address <= '0;
            controller_write_data    <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= IDLE;
                owner[c] <= '0;
            end
        end else begin
            rr_ptr <= next_ptr;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    IDLE: begin
                        if (grant[c]) begin
                            owner[c] <= grant_owner[c];
                            state[c] <= REQ;
                            // Read wins when both are requested; the write waits for a later grant.
                            if (consumer_read_valid[grant_owner[c]]) begin
                                op_write[c]              <= 1'b0;
                                controller_read_valid[c] <= 1'b1;
                                controller_read_address[c*ADDR_BITS +: ADDR_BITS] <=
                                    consumer_read_address[grant_owner[c]*ADDR_BITS +: ADDR_BITS];
                            end else begin
                                op_write[c]               <= 1'b1;
                                controller_write_valid[c] <= 1'b1;
                                controller_write_address[c*ADDR_BITS +: ADDR_BITS] <=
                                    consumer_write_address[grant_owner[c]*ADDR_BITS +: ADDR_BITS];
                                controller_write_data[c*DATA_BITS +: DATA_BITS] <=
                                    consumer_write_data[grant_owner[c]*DATA_BITS +: DATA_BITS];
                            end
                        end
                    end
                    REQ: begin
                        if (!op_write[c] && controller_read_ready[c]) begin
                            controller_read_valid[c]      <= 1'b0;
                            consumer_read_ready[owner[c]] <= 1'b1;
                            consumer_read_data[owner[c]*DATA_BITS +: DATA_BITS] <=
                                controller_read_data[c*DATA_BITS +: DATA_BITS];
                            state[c] <= RESP;
                        end else if (op_write[c] && controller_write_ready[c]) begin
                            controller_write_valid[c]      <= 1'b0;
                            consumer_write_ready[owner[c]] <= 1'b1;
                            state[c] <= RESP;
                        end
                    end
                    RESP: begin
                        if (!op_write[c]) begin
                            if (!consumer_read_valid[owner[c]] && !controller_read_ready[c]) begin
                                consumer_read_ready[owner[c]] <= 1'b0;
                                state[c] <= IDLE;
                            end
                        end else begin
                            if (!consumer_write_valid[owner[c]] && !controller_write_ready[c]) begin
                                consumer_write_ready[owner[c]] <= 1'b0;
                                state[c] <= IDLE;
                            end
                        end
                    end
                    default: state[c] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dcache_channel_arbiter.sv
// Directed bench for dcache_channel_arbiter: 8 consumers, 4 channels, 8-bit address/data.
module tb_dcache_channel_arbiter;
    localparam int A  = 8;
    localparam int D  = 8;
    localparam int NC = 8;
    localparam int NH = 4;

    logic             clk;
    logic             reset;
    logic [NC-1:0]    consumer_read_valid;
    logic [NC*A-1:0]  consumer_read_address;
    logic [NC-1:0]    consumer_read_ready;
    logic [NC*D-1:0]  consumer_read_data;
    logic [NC-1:0]    consumer_write_valid;
    logic [NC*A-1:0]  consumer_write_address;
    logic [NC*D-1:0]  consumer_write_data;
    logic [NC-1:0]    consumer_write_ready;
    logic [NH-1:0]    controller_read_valid;
    logic [NH*A-1:0]  controller_read_address;
    logic [NH-1:0]    controller_read_ready;
    logic [NH*D-1:0]  controller_read_data;
    logic [NH-1:0]    controller_write_valid;
    logic [NH*A-1:0]  controller_write_address;
    logic [NH*D-1:0]  controller_write_data;
    logic [NH-1:0]    controller_write_ready;

    int errors = 0;
    int checks = 0;

    dcache_channel_arbiter #(
        .ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NH)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .consumer_read_valid      (consumer_read_valid),
        .consumer_read_address    (consumer_read_address),
        .consumer_read_ready      (consumer_read_ready),
        .consumer_read_data       (consumer_read_data),
        .consumer_write_valid     (consumer_write_valid),
        .consumer_write_address   (consumer_write_address),
        .consumer_write_data      (consumer_write_data),
        .consumer_write_ready     (consumer_write_ready),
        .controller_read_valid    (controller_read_valid),
        .controller_read_address  (controller_read_address),
        .controller_read_ready    (controller_read_ready),
        .controller_read_data     (controller_read_data),
        .controller_write_valid   (controller_write_valid),
        .controller_write_address (controller_write_address),
        .controller_write_data    (controller_write_data),
        .controller_write_ready   (controller_write_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic drive_read(input int i, input logic v, input logic [A-1:0] addr);
        consumer_read_valid[i]            = v;
        consumer_read_address[i*A +: A]   = addr;
    endtask

    task automatic drive_write(input int i, input logic v, input logic [A-1:0] addr,
                               input logic [D-1:0] data);
        consumer_write_valid[i]           = v;
        consumer_write_address[i*A +: A]  = addr;
        consumer_write_data[i*D +: D]     = data;
    endtask

    task automatic ctrl_read_resp(input int c, input logic r, input logic [D-1:0] data);
        controller_read_ready[c]          = r;
        controller_read_data[c*D +: D]    = data;
    endtask

    function automatic logic [A-1:0] ch_raddr(input int c);
        return controller_read_address[c*A +: A];
    endfunction

    function automatic logic [D-1:0] cons_rdata(input int i);
        return consumer_read_data[i*D +: D];
    endfunction

    task automatic clear_inputs();
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        controller_read_ready  = '0;
        controller_read_data   = '0;
        controller_write_ready = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #12;
        checks++; if (controller_read_valid !== 4'h0 || controller_write_valid !== 4'h0) begin
            errors++; $display("FAIL reset_ctrl_valid: got r=%h w=%h want 0 0", controller_read_valid, controller_write_valid); end
        checks++; if (consumer_read_ready !== 8'h00 || consumer_write_ready !== 8'h00) begin
            errors++; $display("FAIL reset_cons_ready: got r=%h w=%h want 0 0", consumer_read_ready, consumer_write_ready); end
        checks++; if (controller_read_address !== 32'h0 || controller_write_address !== 32'h0 ||
                      controller_write_data !== 32'h0 || consumer_read_data !== 64'h0) begin
            errors++; $display("FAIL reset_data: ra=%h wa=%h wd=%h rd=%h want all 0", controller_read_address,
                               controller_write_address, controller_write_data, consumer_read_data); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        drive_read(0, 1'b1, 8'hFF);
        step();
        checks++; if (controller_read_valid !== 4'b0001 || ch_raddr(0) !== 8'hFF) begin
            errors++; $display("FAIL read_issue: got v=%b a=%h want 0001 ff", controller_read_valid, ch_raddr(0)); end
        checks++; if (consumer_read_ready !== 8'h00) begin
            errors++; $display("FAIL read_early_ready: got %h want 00", consumer_read_ready); end
        ctrl_read_resp(0, 1'b1, 8'hAB);
        step();
        checks++; if (consumer_read_ready !== 8'h01 || cons_rdata(0) !== 8'hAB || controller_read_valid !== 4'b0000) begin
            errors++; $display("FAIL read_done: got rdy=%h d=%h v=%b want 01 ab 0000",
                               consumer_read_ready, cons_rdata(0), controller_read_valid); end
        drive_read(0, 1'b0, 8'hFF);
        ctrl_read_resp(0, 1'b0, 8'h00);
        step();
        checks++; if (consumer_read_ready !== 8'h00 || controller_read_valid !== 4'b0000) begin
            errors++; $display("FAIL read_release: got rdy=%h v=%b want 00 0000", consumer_read_ready, controller_read_valid); end
    endtask

    task automatic test_single_write();
        drive_write(1, 1'b1, 8'hF0, 8'h5A);
        step();
        checks++; if (controller_write_valid !== 4'b0001 || controller_write_address[7:0] !== 8'hF0 ||
                      controller_write_data[7:0] !== 8'h5A) begin
            errors++; $display("FAIL write_issue: got v=%b a=%h d=%h want 0001 f0 5a", controller_write_valid,
                               controller_write_address[7:0], controller_write_data[7:0]); end
        checks++; if (controller_read_valid !== 4'b0000) begin
            errors++; $display("FAIL write_no_read: got %b want 0000", controller_read_valid); end
        controller_write_ready[0] = 1'b1;
        step();
        checks++; if (consumer_write_ready !== 8'h02 || controller_write_valid !== 4'b0000 || consumer_read_ready !== 8'h00) begin
            errors++; $display("FAIL write_done: got wr=%h v=%b rr=%h want 02 0000 00",
                               consumer_write_ready, controller_write_valid, consumer_read_ready); end
        drive_write(1, 1'b0, 8'hF0, 8'h5A);
        controller_write_ready[0] = 1'b0;
        step();
        checks++; if (consumer_write_ready !== 8'h00) begin
            errors++; $display("FAIL write_release: got %h want 00", consumer_write_ready); end
    endtask

    task automatic test_all_read();
        // fresh reset so the pointer starts at consumer 0
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < NC; i++) drive_read(i, 1'b1, 8'(8'h10 + i));
        step();
        checks++; if (controller_read_valid !== 4'hF) begin
            errors++; $display("FAIL all_first_valid: got %b want 1111", controller_read_valid); end
        for (int c = 0; c < NH; c++) begin
            checks++; if (ch_raddr(c) !== 8'(8'h10 + c)) begin
                errors++; $display("FAIL all_first_addr ch%0d: got %h want %h", c, ch_raddr(c), 8'(8'h10 + c)); end
            ctrl_read_resp(c, 1'b1, 8'(8'hC0 + c));
        end
        step();
        checks++; if (consumer_read_ready !== 8'h0F) begin
            errors++; $display("FAIL all_first_ready: got %h want 0f", consumer_read_ready); end
        for (int i = 0; i < NH; i++) begin
            checks++; if (cons_rdata(i) !== 8'(8'hC0 + i)) begin
                errors++; $display("FAIL all_first_data c%0d: got %h want %h", i, cons_rdata(i), 8'(8'hC0 + i)); end
            drive_read(i, 1'b0, 8'h00);
            ctrl_read_resp(i, 1'b0, 8'h00);
        end
        step();
        checks++; if (consumer_read_ready !== 8'h00 || controller_read_valid !== 4'h0) begin
            errors++; $display("FAIL all_idle_gap: got rdy=%h v=%b want 00 0000", consumer_read_ready, controller_read_valid); end
        step();
        for (int c = 0; c < NH; c++) begin
            checks++; if (controller_read_valid[c] !== 1'b1 || ch_raddr(c) !== 8'(8'h14 + c)) begin
                errors++; $display("FAIL all_second_addr ch%0d: got v=%b a=%h want 1 %h", c,
                                   controller_read_valid[c], ch_raddr(c), 8'(8'h14 + c)); end
            ctrl_read_resp(c, 1'b1, 8'(8'hD0 + c));
        end
        step();
        checks++; if (consumer_read_ready !== 8'hF0) begin
            errors++; $display("FAIL all_second_ready: got %h want f0", consumer_read_ready); end
        for (int i = 4; i < NC; i++) begin
            checks++; if (cons_rdata(i) !== 8'(8'hD0 + i - 4)) begin
                errors++; $display("FAIL all_second_data c%0d: got %h want %h", i, cons_rdata(i), 8'(8'hD0 + i - 4)); end
            drive_read(i, 1'b0, 8'h00);
            ctrl_read_resp(i - 4, 1'b0, 8'h00);
        end
        step();
    endtask

    task automatic test_wrap();
        // pointer is 0; a lone grant to consumer 5 moves it to 6
        drive_read(5, 1'b1, 8'h35);
        step();
        ctrl_read_resp(0, 1'b1, 8'h00);
        step();
        drive_read(5, 1'b0, 8'h35);
        ctrl_read_resp(0, 1'b0, 8'h00);
        step();
        drive_read(1, 1'b1, 8'h31);
        drive_read(7, 1'b1, 8'h37);
        step();
        checks++; if (controller_read_valid !== 4'b0011 || ch_raddr(0) !== 8'h37 || ch_raddr(1) !== 8'h31) begin
            errors++; $display("FAIL wrap_grant: got v=%b ch0=%h ch1=%h want 0011 37 31",
                               controller_read_valid, ch_raddr(0), ch_raddr(1)); end
        ctrl_read_resp(0, 1'b1, 8'h77);
        ctrl_read_resp(1, 1'b1, 8'h11);
        step();
        checks++; if (consumer_read_ready !== 8'h82 || cons_rdata(7) !== 8'h77 || cons_rdata(1) !== 8'h11) begin
            errors++; $display("FAIL wrap_done: got rdy=%h d7=%h d1=%h want 82 77 11",
                               consumer_read_ready, cons_rdata(7), cons_rdata(1)); end
        drive_read(1, 1'b0, 8'h31);
        drive_read(7, 1'b0, 8'h37);
        ctrl_read_resp(0, 1'b0, 8'h00);
        ctrl_read_resp(1, 1'b0, 8'h00);
        step();
        // pointer should now be 2: consumer 3 is ahead of consumer 0
        drive_read(0, 1'b1, 8'h30);
        drive_read(3, 1'b1, 8'h33);
        step();
        checks++; if (ch_raddr(0) !== 8'h33 || ch_raddr(1) !== 8'h30 || controller_read_valid !== 4'b0011) begin
            errors++; $display("FAIL wrap_pointer: got v=%b ch0=%h ch1=%h want 0011 33 30",
                               controller_read_valid, ch_raddr(0), ch_raddr(1)); end
        ctrl_read_resp(0, 1'b1, 8'h00);
        ctrl_read_resp(1, 1'b1, 8'h00);
        step();
        drive_read(0, 1'b0, 8'h30);
        drive_read(3, 1'b0, 8'h33);
        ctrl_read_resp(0, 1'b0, 8'h00);
        ctrl_read_resp(1, 1'b0, 8'h00);
        step();
    endtask

    task automatic test_read_then_write();
        drive_read(3, 1'b1, 8'h44);
        drive_write(3, 1'b1, 8'h55, 8'h66);
        step();
        checks++; if (controller_read_valid !== 4'b0001 || ch_raddr(0) !== 8'h44 || controller_write_valid !== 4'b0000) begin
            errors++; $display("FAIL rw_read_first: got rv=%b a=%h wv=%b want 0001 44 0000",
                               controller_read_valid, ch_raddr(0), controller_write_valid); end
        ctrl_read_resp(0, 1'b1, 8'h99);
        step();
        checks++; if (consumer_read_ready !== 8'h08 || cons_rdata(3) !== 8'h99) begin
            errors++; $display("FAIL rw_read_done: got rdy=%h d=%h want 08 99", consumer_read_ready, cons_rdata(3)); end
        drive_read(3, 1'b0, 8'h44);
        step();
        checks++; if (consumer_read_ready !== 8'h08 || controller_write_valid !== 4'b0000) begin
            errors++; $display("FAIL rw_held_ready: got rdy=%h wv=%b want 08 0000", consumer_read_ready, controller_write_valid); end
        ctrl_read_resp(0, 1'b0, 8'h00);
        step();
        checks++; if (consumer_read_ready !== 8'h00 || controller_write_valid !== 4'b0000) begin
            errors++; $display("FAIL rw_idle_no_grant: got rdy=%h wv=%b want 00 0000", consumer_read_ready, controller_write_valid); end
        step();
        checks++; if (controller_write_valid !== 4'b0001 || controller_write_address[7:0] !== 8'h55 ||
                      controller_write_data[7:0] !== 8'h66) begin
            errors++; $display("FAIL rw_write_grant: got v=%b a=%h d=%h want 0001 55 66", controller_write_valid,
                               controller_write_address[7:0], controller_write_data[7:0]); end
        controller_write_ready[0] = 1'b1;
        step();
        checks++; if (consumer_write_ready !== 8'h08) begin
            errors++; $display("FAIL rw_write_done: got %h want 08", consumer_write_ready); end
        drive_write(3, 1'b0, 8'h55, 8'h66);
        controller_write_ready[0] = 1'b0;
        step();
    endtask

    task automatic test_reset_inflight();
        // pointer is 4 here, so consumer 5 lands on channel 0 before reset
        drive_read(2, 1'b1, 8'h22);
        drive_read(5, 1'b1, 8'h25);
        step();
        checks++; if (controller_read_valid !== 4'b0011 || ch_raddr(0) !== 8'h25 || ch_raddr(1) !== 8'h22) begin
            errors++; $display("FAIL rst_pre: got v=%b ch0=%h ch1=%h want 0011 25 22",
                               controller_read_valid, ch_raddr(0), ch_raddr(1)); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (controller_read_valid !== 4'b0000 || consumer_read_ready !== 8'h00 || controller_read_address !== 32'h0) begin
            errors++; $display("FAIL rst_async: got v=%b rdy=%h a=%h want 0000 00 0",
                               controller_read_valid, consumer_read_ready, controller_read_address); end
        #1;
        reset = 1'b1;
        step();
        checks++; if (controller_read_valid !== 4'b0011 || ch_raddr(0) !== 8'h22 || ch_raddr(1) !== 8'h25) begin
            errors++; $display("FAIL rst_regrant: got v=%b ch0=%h ch1=%h want 0011 22 25",
                               controller_read_valid, ch_raddr(0), ch_raddr(1)); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_all_read();
        test_wrap();
        test_read_then_write();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_channel_arbiter.md
Name: dcache_channel_arbiter

Overview:
- Sits between the dcache miss/write-through request ports and the memory controller channels.
- Shares NUM_CHANNELS controller channels among NUM_CONSUMERS requesters using round-robin allocation.
- Runs a per-channel four-phase handshake FSM on both the consumer side and the controller side.
- Returns read data and write acknowledges to the owning consumer.

Parameters:
ADDR_BITS, 8, address width
DATA_BITS, 8, data width
NUM_CONSUMERS, 8, requester count; must be ≥1
NUM_CHANNELS, 4, controller channel count; must be ≥1 and ≤NUM_CONSUMERS

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request
consumer_read_address  input  [NUM_CONSUMERS] x ADDR_BITS  read address
consumer_read_ready  output  NUM_CONSUMERS  read done; data valid
consumer_read_data  output  [NUM_CONSUMERS] x DATA_BITS  returned read data
consumer_write_valid  input  NUM_CONSUMERS  per-consumer write request
consumer_write_address  input  [NUM_CONSUMERS] x ADDR_BITS  write address
consumer_write_data  input  [NUM_CONSUMERS] x DATA_BITS  write data
consumer_write_ready  output  NUM_CONSUMERS  write done
controller_read_valid  output  NUM_CHANNELS  channel read request
controller_read_address  output  [NUM_CHANNELS] x ADDR_BITS  channel read address
controller_read_ready  input  NUM_CHANNELS  controller read complete
controller_read_data  input  [NUM_CHANNELS] x DATA_BITS  controller read data
controller_write_valid  output  NUM_CHANNELS  channel write request
controller_write_address  output  [NUM_CHANNELS] x ADDR_BITS  channel write address
controller_write_data  output  [NUM_CHANNELS] x DATA_BITS  channel write data
controller_write_ready  input  NUM_CHANNELS  controller write complete

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0 immediately.
  - All channels return to IDLE; the round-robin pointer is cleared to 0.
  - An in-flight transaction is dropped. The consumer must re-present it.
- All outputs are registered.
- Per-channel state holds owner (consumer index), op (read/write), captured address/data and FSM state.
- Channel FSM:
  - IDLE: the channel is free.
    - On grant, go to REQ with controller_*_valid=1 and address/data from the owner, visible the cycle after grant.
  - REQ: hold valid, address and data stable.
    - On a clk edge with the matching controller_*_ready=1: controller_*_valid goes 0.
    - Reads also capture controller_read_data into consumer_read_data[owner].
    - consumer_*_ready[owner] goes 1. Go to RESP.
  - RESP: hold consumer_*_ready[owner]=1 and consumer_read_data stable.
    - Go to IDLE, with ready to 0, on the first edge where both consumer_*_valid[owner]=0 and controller_*_ready=0.
    - If only one condition holds, wait.
- Arbitration (every cycle):
  - pending[i] = (read_valid[i] | write_valid[i]) and i not owned by any channel.
  - Free channels are granted in ascending index order to pending consumers in round-robin order, starting at the pointer and wrapping modulo NUM_CONSUMERS.
  - Grants per cycle = min(free channels, pending consumers).
  - After any grant, the pointer becomes (last granted index + 1) mod NUM_CONSUMERS. With no grant, the pointer is unchanged.
  - A channel entering IDLE this edge is not re-granted until the next edge. Each channel has one grant per RESP→IDLE cycle minimum.
- A consumer with both read_valid and write_valid high:
  - The read is granted first.
  - The write becomes pending only after the read channel returns to IDLE, provided write_valid is still high.
- A consumer owns at most one channel at a time.
- Latency, uncontended: consumer valid sampled at edge E0 → controller valid high after E0. Controller ready sampled at E1 → consumer ready high after E1.
- A controller ready on a channel not in REQ, or of the wrong op type, is ignored.
- Deasserting consumer valid while in REQ does not cancel the request. The transaction completes and RESP exits as soon as controller ready drops.

Test Plan:
- Reset with consumers idle → all outputs 0; release reset, consumer 0 read 0xFF → controller_read_valid[0]=1, addr 0xFF next cycle; controller ready=1 with data 0xAB → consumer_read_ready[0]=1, data 0xAB next cycle; drop both valid and ready → ready=0 after one edge.
- Consumer 1 write addr 0xF0 data 0x5A → controller_write_valid[0]=1, addr 0xF0, data 0x5A; write_ready=1 → consumer_write_ready[1]=1; no read outputs toggle.
- All 8 consumers read at once with 4 channels → channels 0-3 granted to consumers 0-3; pointer=4; as channels complete, consumers 4-7 granted in order; every consumer sees the data driven on its channel.
- Wrap-around: pointer=6, consumers 1 and 7 pending, 2 free channels → channel 0 to consumer 7, channel 1 to consumer 1, pointer=2.
- Consumer 3 asserts read and write together → read is served first on one channel; the write is granted only after the read channel reaches IDLE. A held controller ready delays the return to IDLE.
- Assert reset while 2 channels are in REQ → all valid/ready outputs drop in the same cycle without a clk edge; after release, re-presented requests are granted starting from consumer 0.
